mem_stage_sequencer: RTL and testbench
======================================

Name: mem_stage_sequencer

Overview:
- MEM-stage consumer of the decoded control word.
- Takes the opcode and effective address produced upstream and runs the data-memory access sequence on the split D-side memory port:
  - single access for LDR/STR/LDB/STB;
  - two accesses (pointer fetch, then data) for LDI/STI.
- Holds the pipeline via stall until the access completes, then presents load data for writeback.

Parameters:
- None. Widths are fixed by lc3b_types: 16-bit word, 4-bit opcode, 2-bit byte mask.

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous, active-low reset
- valid_in  in  1  MEM stage holds a valid instruction
- opcode  in  4  lc3b_opcode of the MEM-stage instruction
- addr  in  16  effective address from EX
- store_data  in  16  SR value for stores
- mem_resp  in  1  memory completes the current request this cycle
- mem_rdata  in  16  read data, valid with mem_resp
- mem_read  out  1  read request, held until mem_resp
- mem_write  out  1  write request, held until mem_resp
- mem_address  out  16  word-aligned request address
- mem_wdata  out  16  write data
- mem_byte_enable  out  2  write byte mask
- stall  out  1  freeze IF/ID/EX/MEM pipeline registers
- load_data  out  16  writeback data, valid when done=1
- done  out  1  one-cycle pulse: memory instruction complete

Behaviour:
- Reset:
  - clk and rst_n are a single clock domain; reset is synchronous, active-low.
  - In reset: state=IDLE; mem_read=mem_write=0; mem_address=mem_wdata=load_data=0; mem_byte_enable=2'b00; done=0.
  - stall = valid_in & is_mem(opcode). is_mem = LDR, STR, LDB, STB, LDI, STI.
- States: IDLE, ACC1, ACC2, COMPLETE.
- IDLE:
  - If valid_in & is_mem: capture opcode, addr and store_data into internal regs; stall=1; go to ACC1.
  - Otherwise stall=0 and state stays IDLE. Non-memory opcodes pass through with zero added latency.
- ACC1:
  - mem_address = {addr_q[15:1],1'b0}.
  - LDR/LDB/LDI/STI: mem_read=1.
  - STR: mem_write=1, mem_wdata=store_q, mem_byte_enable=2'b11.
  - STB: mem_write=1, mem_wdata={store_q[7:0],store_q[7:0]}, mem_byte_enable = addr_q[0] ? 2'b10 : 2'b01.
  - On mem_resp: LDI/STI latch mem_rdata as ptr_q and go to ACC2; all others go to COMPLETE.
  - Without mem_resp: request held stable, stall=1.
- ACC2:
  - mem_address = {ptr_q[15:1],1'b0}.
  - LDI: mem_read=1.
  - STI: mem_write=1, mem_wdata=store_q, mem_byte_enable=2'b11.
  - On mem_resp go to COMPLETE.
- Request deassert: mem_read and mem_write drop in the cycle after mem_resp. There is never a back-to-back request without a state change.
- load_data:
  - Registered on the final mem_resp.
  - LDR/LDI: mem_rdata.
  - LDB: zero-extended byte, selected by addr_q[0] (1 = high byte).
  - Stores: 16'h0000.
- COMPLETE:
  - stall=0, done=1, no request.
  - Pipeline advances on this edge; next state IDLE unconditionally, so the same instruction is not re-issued.
- Latency with zero-wait memory (mem_resp in the first request cycle):
  - Single access: 3 cycles, stall high 2.
  - LDI/STI: 4 cycles, stall high 3.
  - Each memory wait cycle adds 1.
- Boundary conditions:
  - mem_resp in IDLE/COMPLETE is ignored.
  - valid_in or opcode changing after capture is ignored; the operation runs to completion.
  - Odd addr on a word op: bit 0 is forced to 0, with no fault.
  - Reset asserted mid-ACC1/ACC2 aborts the operation: requests are 0 in the next cycle, and a late mem_resp is ignored.

Decomposition:
- lc3b_types: add mem_seq_state enum {IDLE, ACC1, ACC2, COMPLETE}, lc3b_mem_wmask (2-bit), and an is_mem_op function alongside the existing lc3b_opcode and lc3b_word.
- One combinational sub-module, mem_byte_align:
  - inputs: opcode, addr[0], store_data, mem_rdata;
  - outputs: mem_wdata, mem_byte_enable, aligned load value.
- The FSM stays in mem_stage_sequencer.

Test Plan:
- LDR, addr=0x3002, mem_rdata=0xBEEF, zero wait: mem_read=1 with mem_address=0x3002 in cycle 1; cycle 2 done=1, load_data=0xBEEF; stall=1 in cycles 0-1 only.
- LDB, addr=0x4001, mem_rdata=0x12AB, 2 wait cycles: mem_address=0x4000, read held 3 cycles, load_data=0x0012; then with addr=0x4000, load_data=0x00AB.
- STB, addr=0x5003, store_data=0x77C4: mem_write=1, mem_address=0x5002, mem_wdata=0xC4C4, mem_byte_enable=2'b10.
- LDI, addr=0x6000, first read returns 0x7010, second returns 0x1234: addresses 0x6000 then 0x7010; load_data=0x1234; stall high exactly 3 cycles.
- STI, addr=0x6000 with pointer 0x8000, store_data=0xA5A5: read at 0x6000, then write 0xA5A5 at 0x8000 with mask 2'b11; an ADD in the following instruction sees stall=0 and done=0.
- rst_n=0 during ACC2 of LDI: next cycle mem_read=0, state IDLE, done never pulses; a mem_resp arriving after reset leaves load_data=0.

Source files
------------

// File: rtl/mem_stage_sequencer_pkg.sv
// Shared LC-3b types for the MEM-stage data-memory sequencer.
// Opcodes, word/mask widths, sequencer state encoding and the memory-op classifier.
package mem_stage_sequencer_pkg;

  localparam int unsigned WORD_W   = 16;
  localparam int unsigned OPCODE_W = 4;
  localparam int unsigned WMASK_W  = 2;

  typedef logic [WORD_W-1:0]   lc3b_word;
  typedef logic [OPCODE_W-1:0] lc3b_opcode;
  typedef logic [WMASK_W-1:0]  lc3b_mem_wmask;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ACC1     = 2'd1,
    ACC2     = 2'd2,
    COMPLETE = 2'd3
  } mem_seq_state;

  localparam lc3b_opcode OP_BR   = 4'b0000;
  localparam lc3b_opcode OP_ADD  = 4'b0001;
  localparam lc3b_opcode OP_LDB  = 4'b0010;
  localparam lc3b_opcode OP_STB  = 4'b0011;
  localparam lc3b_opcode OP_JSR  = 4'b0100;
  localparam lc3b_opcode OP_AND  = 4'b0101;
  localparam lc3b_opcode OP_LDR  = 4'b0110;
  localparam lc3b_opcode OP_STR  = 4'b0111;
  localparam lc3b_opcode OP_RTI  = 4'b1000;
  localparam lc3b_opcode OP_NOT  = 4'b1001;
  localparam lc3b_opcode OP_LDI  = 4'b1010;
  localparam lc3b_opcode OP_STI  = 4'b1011;
  localparam lc3b_opcode OP_JMP  = 4'b1100;
  localparam lc3b_opcode OP_SHF  = 4'b1101;
  localparam lc3b_opcode OP_LEA  = 4'b1110;
  localparam lc3b_opcode OP_TRAP = 4'b1111;

  // True for every opcode that touches data memory.
  function automatic logic is_mem_op(input lc3b_opcode op);
    return (op == OP_LDR) || (op == OP_STR) || (op == OP_LDB) ||
           (op == OP_STB) || (op == OP_LDI) || (op == OP_STI);
  endfunction

  // True for the two-access indirect opcodes.
  function automatic logic is_indirect_op(input lc3b_opcode op);
    return (op == OP_LDI) || (op == OP_STI);
  endfunction

endpackage

// File: rtl/mem_stage_sequencer_byte_align.sv
// Byte lane steering for the D-side port: write data/mask formation and load extraction.
// Purely combinational; the sequencer decides when each output is used.
module mem_byte_align
  import mem_stage_sequencer_pkg::*;
(
  input  lc3b_opcode    opcode,
  input  logic          addr_lsb,
  input  lc3b_word      store_data,
  input  lc3b_word      mem_rdata,
  output lc3b_word      mem_wdata,
  output lc3b_mem_wmask mem_byte_enable,
  output lc3b_word      load_value
);

  always_comb begin
    mem_wdata       = '0;
    mem_byte_enable = '0;
    load_value      = '0;
    case (opcode)
      OP_STR, OP_STI: begin
        mem_wdata       = store_data;
        mem_byte_enable = 2'b11;
      end
      OP_STB: begin
        // Byte replicated on both lanes; the mask picks the lane that lands.
        mem_wdata       = {store_data[7:0], store_data[7:0]};
        mem_byte_enable = addr_lsb ? 2'b10 : 2'b01;
      end
      OP_LDR, OP_LDI: load_value = mem_rdata;
      OP_LDB:         load_value = {8'h00, (addr_lsb ? mem_rdata[15:8] : mem_rdata[7:0])};
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_stage_sequencer.sv
// MEM-stage sequencer: runs one or two D-side accesses per memory instruction,
// stalls the pipeline meanwhile and pulses done with the writeback value.
module mem_stage_sequencer
  import mem_stage_sequencer_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          valid_in,
  input  lc3b_opcode    opcode,
  input  lc3b_word      addr,
  input  lc3b_word      store_data,
  input  logic          mem_resp,
  input  lc3b_word      mem_rdata,
  output logic          mem_read,
  output logic          mem_write,
  output lc3b_word      mem_address,
  output lc3b_word      mem_wdata,
  output lc3b_mem_wmask mem_byte_enable,
  output logic          stall,
  output lc3b_word      load_data,
  output logic          done
);

  mem_seq_state  state;
  lc3b_opcode    op_q;
  logic          addr_lsb_q;
  lc3b_word      store_q;

  lc3b_opcode    align_op;
  logic          align_lsb;
  lc3b_word      align_store;
  lc3b_word      align_wdata;
  lc3b_mem_wmask align_be;
  lc3b_word      align_load;
  logic          capture;
  logic          first_is_write;

  // In IDLE the aligner sees the incoming instruction so ACC1's request can be registered.
  assign align_op    = (state == IDLE) ? opcode     : op_q;
  assign align_lsb   = (state == IDLE) ? addr[0]    : addr_lsb_q;
  assign align_store = (state == IDLE) ? store_data : store_q;

  assign capture        = valid_in && is_mem_op(opcode);
  assign first_is_write = (opcode == OP_STR) || (opcode == OP_STB);

  mem_byte_align u_align (
    .opcode          (align_op),
    .addr_lsb        (align_lsb),
    .store_data      (align_store),
    .mem_rdata       (mem_rdata),
    .mem_wdata       (align_wdata),
    .mem_byte_enable (align_be),
    .load_value      (align_load)
  );

  // Stall covers the issuing cycle and every access cycle.
  always_comb begin
    stall = 1'b0;
    case (state)
      IDLE:       stall = capture;
      ACC1, ACC2: stall = 1'b1;
      default:    stall = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state           <= IDLE;
      op_q            <= '0;
      addr_lsb_q      <= 1'b0;
      store_q         <= '0;
      mem_read        <= 1'b0;
      mem_write       <= 1'b0;
      mem_address     <= '0;
      mem_wdata       <= '0;
      mem_byte_enable <= '0;
      load_data       <= '0;
      done            <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (capture) begin
            op_q            <= opcode;
            addr_lsb_q      <= addr[0];
            store_q         <= store_data;
            mem_address     <= {addr[15:1], 1'b0};
            mem_read        <= !first_is_write;
            mem_write       <= first_is_write;
            mem_wdata       <= first_is_write ? align_wdata : '0;
            mem_byte_enable <= first_is_write ? align_be : '0;
            state           <= ACC1;
          end
        end
        ACC1: begin
          if (mem_resp) begin
            if (is_indirect_op(op_q)) begin
              // Returned word is the pointer for the second access.
              mem_address     <= {mem_rdata[15:1], 1'b0};
              mem_read        <= (op_q == OP_LDI);
              mem_write       <= (op_q == OP_STI);
              mem_wdata       <= align_wdata;
              mem_byte_enable <= align_be;
              state           <= ACC2;
            end else begin
              mem_read        <= 1'b0;
              mem_write       <= 1'b0;
              mem_wdata       <= '0;
              mem_byte_enable <= '0;
              load_data       <= align_load;
              done            <= 1'b1;
              state           <= COMPLETE;
            end
          end
        end
        ACC2: begin
          if (mem_resp) begin
            mem_read        <= 1'b0;
            mem_write       <= 1'b0;
            mem_wdata       <= '0;
            mem_byte_enable <= '0;
            load_data       <= align_load;
            done            <= 1'b1;
            state           <= COMPLETE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage_sequencer.sv
// Self-checking bench for mem_stage_sequencer: directed scenarios plus randomized
// instruction streams against a transaction-level model with a wait-state memory.
module tb_mem_stage_sequencer;

  localparam logic [3:0] ADD = 4'b0001;
  localparam logic [3:0] LDB = 4'b0010;
  localparam logic [3:0] STB = 4'b0011;
  localparam logic [3:0] LDR = 4'b0110;
  localparam logic [3:0] STR = 4'b0111;
  localparam logic [3:0] LDI = 4'b1010;
  localparam logic [3:0] STI = 4'b1011;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid_in;
  logic [3:0]  opcode;
  logic [15:0] addr;
  logic [15:0] store_data;
  logic        mem_resp;
  logic [15:0] mem_rdata;
  logic        mem_read;
  logic        mem_write;
  logic [15:0] mem_address;
  logic [15:0] mem_wdata;
  logic [1:0]  mem_byte_enable;
  logic        stall;
  logic [15:0] load_data;
  logic        done;

  int n_tests = 0;
  int n_fail  = 0;

  // Expected access list for the instruction in flight.
  int          n_acc;
  bit          exp_wr  [2];
  logic [15:0] exp_adr [2];
  logic [15:0] exp_wd  [2];
  logic [1:0]  exp_be  [2];
  logic [15:0] exp_load;

  always #5 clk = ~clk;

  mem_stage_sequencer dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .valid_in        (valid_in),
    .opcode          (opcode),
    .addr            (addr),
    .store_data      (store_data),
    .mem_resp        (mem_resp),
    .mem_rdata       (mem_rdata),
    .mem_read        (mem_read),
    .mem_write       (mem_write),
    .mem_address     (mem_address),
    .mem_wdata       (mem_wdata),
    .mem_byte_enable (mem_byte_enable),
    .stall           (stall),
    .load_data       (load_data),
    .done            (done)
  );

  // Architectural view: which accesses an instruction makes and what it writes back.
  task automatic build_model(input logic [3:0] op, input logic [15:0] a, input logic [15:0] s,
                             input logic [15:0] r1, input logic [15:0] r2);
    logic [15:0] aw;
    aw       = a & 16'hFFFE;
    n_acc    = 0;
    exp_load = 16'h0000;
    exp_wd[0] = 16'h0; exp_wd[1] = 16'h0;
    exp_be[0] = 2'b00; exp_be[1] = 2'b00;
    exp_wr[0] = 1'b0;  exp_wr[1] = 1'b0;
    exp_adr[0] = aw;   exp_adr[1] = r1 & 16'hFFFE;
    case (op)
      LDR: begin n_acc = 1; exp_load = r1; end
      LDB: begin n_acc = 1; exp_load = a[0] ? (r1 >> 8) : (r1 & 16'h00FF); end
      STR: begin n_acc = 1; exp_wr[0] = 1'b1; exp_wd[0] = s; exp_be[0] = 2'b11; end
      STB: begin
        n_acc = 1; exp_wr[0] = 1'b1;
        exp_wd[0] = (s & 16'h00FF) * 16'h0101;
        exp_be[0] = a[0] ? 2'b10 : 2'b01;
      end
      LDI: begin n_acc = 2; exp_load = r2; end
      STI: begin n_acc = 2; exp_wr[1] = 1'b1; exp_wd[1] = s; exp_be[1] = 2'b11; end
      default: n_acc = 0;
    endcase
  endtask

  // Issue one instruction and act as the memory, checking every cycle until done.
  task automatic run_op(input logic [3:0] op, input logic [15:0] a, input logic [15:0] s,
                        input logic [15:0] r1, input logic [15:0] r2, input int w1, input int w2);
    logic [15:0] rd [2];
    int          w  [2];
    int          idx, cnt, stalls, total_wait;
    bit          fin;
    build_model(op, a, s, r1, r2);
    rd[0] = r1; rd[1] = r2; w[0] = w1; w[1] = w2;
    total_wait = w1 + ((n_acc > 1) ? w2 : 0);

    @(negedge clk);
    valid_in = 1'b1; opcode = op; addr = a; store_data = s;
    mem_resp = 1'($urandom); mem_rdata = 16'($urandom);
    #1;
    n_tests++;
    if (stall !== (n_acc > 0) || done !== 1'b0 || mem_read !== 1'b0 || mem_write !== 1'b0) begin
      n_fail++;
      $display("FAIL issue op=%h: stall=%b done=%b rd=%b wr=%b, required stall=%b done=0 rd=0 wr=0",
               op, stall, done, mem_read, mem_write, (n_acc > 0));
    end

    if (n_acc == 0) begin
      @(negedge clk);
      valid_in = 1'b0; mem_resp = 1'b0;
      n_tests++;
      if (done !== 1'b0 || mem_read !== 1'b0 || mem_write !== 1'b0 || stall !== 1'b0) begin
        n_fail++;
        $display("FAIL pass_through op=%h: done=%b rd=%b wr=%b stall=%b, required all 0",
                 op, done, mem_read, mem_write, stall);
      end
      return;
    end

    idx = 0; cnt = 0; stalls = 1; fin = 1'b0;
    for (int c = 0; c < 40 && !fin; c++) begin
      @(negedge clk);
      // Inputs after capture are noise the sequencer must ignore.
      valid_in = 1'($urandom); opcode = 4'($urandom);
      addr = 16'($urandom); store_data = 16'($urandom);
      if (stall === 1'b1) stalls++;
      if (idx < n_acc) begin
        n_tests++;
        if (mem_read !== !exp_wr[idx] || mem_write !== exp_wr[idx] ||
            mem_address !== exp_adr[idx] || stall !== 1'b1 || done !== 1'b0 ||
            (exp_wr[idx] && (mem_wdata !== exp_wd[idx] || mem_byte_enable !== exp_be[idx]))) begin
          n_fail++;
          $display("FAIL access%0d op=%h: rd=%b wr=%b adr=%h wd=%h be=%b stall=%b done=%b, required rd=%b wr=%b adr=%h wd=%h be=%b stall=1 done=0",
                   idx, op, mem_read, mem_write, mem_address, mem_wdata, mem_byte_enable, stall, done,
                   !exp_wr[idx], exp_wr[idx], exp_adr[idx], exp_wd[idx], exp_be[idx]);
        end
        if (cnt < w[idx]) begin
          mem_resp = 1'b0; cnt++;
        end else begin
          mem_resp = 1'b1;
          mem_rdata = exp_wr[idx] ? 16'($urandom) : rd[idx];
          idx++; cnt = 0;
        end
      end else begin
        n_tests++;
        if (done !== 1'b1 || mem_read !== 1'b0 || mem_write !== 1'b0 || stall !== 1'b0 ||
            load_data !== exp_load) begin
          n_fail++;
          $display("FAIL complete op=%h: done=%b rd=%b wr=%b stall=%b load=%h, required done=1 rd=0 wr=0 stall=0 load=%h",
                   op, done, mem_read, mem_write, stall, load_data, exp_load);
        end
        fin = 1'b1;
        valid_in = 1'b0;
        mem_resp = 1'($urandom); mem_rdata = 16'($urandom);
      end
    end

    n_tests++;
    if (!fin) begin
      n_fail++;
      $display("FAIL timeout op=%h: done not seen within 40 cycles", op);
    end else if (stalls != 1 + n_acc + total_wait) begin
      n_fail++;
      $display("FAIL stall_count op=%h: got %0d cycles, required %0d", op, stalls, 1 + n_acc + total_wait);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; valid_in = 1'b1; opcode = LDR; addr = 16'h1235; store_data = 16'hFFFF;
    mem_resp = 1'b1; mem_rdata = 16'hFFFF;
    repeat (3) @(negedge clk);
    n_tests++;
    if (mem_read !== 1'b0 || mem_write !== 1'b0 || mem_address !== 16'h0 || mem_wdata !== 16'h0 ||
        mem_byte_enable !== 2'b00 || load_data !== 16'h0 || done !== 1'b0 || stall !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_state: rd=%b wr=%b adr=%h wd=%h be=%b load=%h done=%b stall=%b, required zeros with stall=1",
               mem_read, mem_write, mem_address, mem_wdata, mem_byte_enable, load_data, done, stall);
    end
    valid_in = 1'b0; mem_resp = 1'b0;
    #1;
    n_tests++;
    if (stall !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_stall_idle: stall=%b, required 0", stall);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_ldr();
    run_op(LDR, 16'h3002, 16'h0000, 16'hBEEF, 16'h0000, 0, 0);
  endtask

  task automatic test_ldb();
    run_op(LDB, 16'h4001, 16'h0000, 16'h12AB, 16'h0000, 2, 0);
    run_op(LDB, 16'h4000, 16'h0000, 16'h12AB, 16'h0000, 0, 0);
  endtask

  task automatic test_stb();
    run_op(STB, 16'h5003, 16'h77C4, 16'h0000, 16'h0000, 0, 0);
    run_op(STR, 16'h5001, 16'h9A3C, 16'h0000, 16'h0000, 1, 0);
  endtask

  task automatic test_ldi();
    run_op(LDI, 16'h6000, 16'h0000, 16'h7010, 16'h1234, 0, 0);
  endtask

  task automatic test_sti_then_add();
    run_op(STI, 16'h6000, 16'hA5A5, 16'h8000, 16'h0000, 0, 0);
    run_op(ADD, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 0, 0);
  endtask

  task automatic test_reset_mid_ldi();
    @(negedge clk);
    valid_in = 1'b1; opcode = LDI; addr = 16'h6000; mem_resp = 1'b0;
    @(negedge clk);
    valid_in = 1'b0;
    mem_resp = 1'b1; mem_rdata = 16'h7010;
    @(negedge clk);
    n_tests++;
    if (mem_read !== 1'b1 || mem_address !== 16'h7010) begin
      n_fail++;
      $display("FAIL abort_acc2_entry: rd=%b adr=%h, required rd=1 adr=7010", mem_read, mem_address);
    end
    mem_resp = 1'b0; rst_n = 1'b0;
    @(negedge clk);
    n_tests++;
    if (mem_read !== 1'b0 || mem_write !== 1'b0 || done !== 1'b0 || stall !== 1'b0 || load_data !== 16'h0) begin
      n_fail++;
      $display("FAIL abort_next_cycle: rd=%b wr=%b done=%b stall=%b load=%h, required all 0",
               mem_read, mem_write, done, stall, load_data);
    end
    rst_n = 1'b1; mem_resp = 1'b1; mem_rdata = 16'h1234;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_tests++;
      if (done !== 1'b0 || load_data !== 16'h0 || mem_read !== 1'b0) begin
        n_fail++;
        $display("FAIL abort_late_resp%0d: done=%b load=%h rd=%b, required 0", i, done, load_data, mem_read);
      end
    end
    mem_resp = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [3:0] op;
    for (int i = 0; i < 80; i++) begin
      case ($urandom_range(0, 6))
        0: op = LDR;
        1: op = STR;
        2: op = LDB;
        3: op = STB;
        4: op = LDI;
        5: op = STI;
        default: op = ADD;
      endcase
      run_op(op, 16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom),
             $urandom_range(0, 3), $urandom_range(0, 3));
    end
  endtask

  initial begin
    rst_n = 1'b0; valid_in = 1'b0; opcode = 4'h0; addr = 16'h0; store_data = 16'h0;
    mem_resp = 1'b0; mem_rdata = 16'h0;
    test_reset();
    test_ldr();
    test_ldb();
    test_stb();
    test_ldi();
    test_sti_then_add();
    test_reset_mid_ldi();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
